// File: rtl/spr_edge_detect_mc_pkg.sv
// spr_pkg: shared FSM states, edge flag bit positions and default widths for the SPR edge detector
package spr_pkg;
   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
   localparam int EDGE2_B = 3;
   localparam int EDGE3_B = 2;
   localparam int EDGE4_B = 1;
   localparam int EDGE5_B = 0;
   localparam int DW_DEF = 12;
   localparam int NCH_DEF = 3;
   localparam int TW_DEF = 12;
   localparam int SHIFT_DEF = 4;
   localparam int CW_DEF = 12;
endpackage

// File: rtl/spr_edge_detect_mc_if.sv
// spr_edge_detect_mc_if: pixel stream in, classified centre pixel out
// SPR_EDGE_STATS_EN adds the per-line edge count and its strobe
interface spr_edge_detect_mc_if #(
   parameter int DW = 12,
   parameter int NCH = 3,
   parameter int TW = 12,
   parameter int CW = 12
);
   logic                i_hs;
   logic                i_vs;
   logic [NCH*DW-1:0]   i_pix;
   logic [TW-1:0]       spr_thr_edge;
   logic                o_valid;
   logic [NCH*DW-1:0]   o_pix;
   logic                o_border;
   logic [NCH-1:0]      o_original;
   logic [4*NCH-1:0]    o_edge;
`ifdef SPR_EDGE_STATS_EN
   logic [CW-1:0]       o_line_edge_cnt;
   logic                o_stats_valid;
   modport master (output i_hs, i_vs, i_pix, spr_thr_edge,
                   input o_valid, o_pix, o_border, o_original, o_edge, o_line_edge_cnt, o_stats_valid);
   modport slave  (input i_hs, i_vs, i_pix, spr_thr_edge,
                   output o_valid, o_pix, o_border, o_original, o_edge, o_line_edge_cnt, o_stats_valid);
`else
   modport master (output i_hs, i_vs, i_pix, spr_thr_edge,
                   input o_valid, o_pix, o_border, o_original, o_edge);
   modport slave  (input i_hs, i_vs, i_pix, spr_thr_edge,
                   output o_valid, o_pix, o_border, o_original, o_edge);
`endif
endinterface

// File: rtl/spr_edge_detect_mc_classify.sv
// spr_edge_classify: one channel's original flag and {edge2,edge3,edge4,edge5} from a prev/curr/next window
module spr_edge_classify import spr_pkg::*; #(
   parameter int DW = DW_DEF,
   parameter int TW = TW_DEF,
   parameter int SHIFT = SHIFT_DEF
) (
   input  logic [DW-1:0] prev_i,
   input  logic [DW-1:0] curr_i,
   input  logic [DW-1:0] next_i,
   input  logic [TW-1:0] thr_i,
   output logic          original_o,
   output logic [3:0]    edge_o
);
   localparam int AW = (DW + 1 > TW) ? DW + 1 : TW;
   logic [DW:0]   dp, dn, mp, mn;
   logic [AW-1:0] ap, an, thr;
   logic          neg, p_ge, n_ge, n_gt;
   assign dp = {1'b0, curr_i} - {1'b0, prev_i};
   assign dn = {1'b0, curr_i} - {1'b0, next_i};
   assign mp = dp[DW] ? -dp : dp;
   assign mn = dn[DW] ? -dn : dn;
   assign ap = AW'(mp >> SHIFT);
   assign an = AW'(mn >> SHIFT);
   assign thr = AW'(thr_i);
   assign neg = dp[DW];
   assign p_ge = ap >= thr;
   assign n_ge = an >= thr;
   assign n_gt = an > thr;
   // an == thr lands in edge2 on a rising step but edge4 on a falling one
   assign edge_o[EDGE2_B] = !neg && p_ge && n_ge;
   assign edge_o[EDGE3_B] = !neg && p_ge && !n_ge;
   assign edge_o[EDGE4_B] = neg && p_ge && !n_gt;
   assign edge_o[EDGE5_B] = neg && p_ge && n_gt;
   assign original_o = (prev_i == '0) ^ (curr_i == '0);
endmodule

// File: rtl/spr_edge_detect_mc.sv
// spr_edge_detect_mc: streaming multi-channel edge detector with border replication and end-of-line flush
// SPR_EDGE_STATS_EN adds a saturating per-line count of results carrying any edge flag
module spr_edge_detect_mc import spr_pkg::*; #(
   parameter int DW = DW_DEF,
   parameter int NCH = NCH_DEF,
   parameter int TW = TW_DEF,
   parameter int SHIFT = SHIFT_DEF,
   parameter int CW = CW_DEF
) (
   input logic clk,
   input logic rst,
   spr_edge_detect_mc_if.slave bus
);
   localparam int PW = NCH * DW;
   state_t            state_q, state_d;
   logic [PW-1:0]     cur_q, cur_d, prv_q, prv_d, win_p, win_n;
   logic              acc, gap, eval, bdr, last;
   logic [NCH-1:0]    orig_w, orig_q;
   logic [4*NCH-1:0]  edge_w, edge_q;
   logic [PW-1:0]     pix_q;
   logic              valid_q, border_q;
   assign acc = bus.i_hs && bus.i_vs;
   assign gap = !bus.i_hs && bus.i_vs;
   // cur_q is the centre pixel; the incoming pixel is the right neighbour
   always_comb begin
      state_d = state_q;
      cur_d = cur_q;
      prv_d = prv_q;
      win_p = (state_q == FILL) ? cur_q : prv_q;
      win_n = gap ? cur_q : bus.i_pix;
      eval = 1'b0;
      bdr = 1'b0;
      last = 1'b0;
      if (!bus.i_vs) state_d = IDLE;
      else case (state_q)
         IDLE: if (acc) begin
            cur_d = bus.i_pix;
            state_d = FILL;
         end
         FILL, RUN: if (acc) begin
            eval = 1'b1;
            bdr = state_q == FILL;
            prv_d = cur_q;
            cur_d = bus.i_pix;
            state_d = RUN;
         end else if (gap) begin
            eval = 1'b1;
            bdr = 1'b1;
            last = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      spr_edge_classify #(.DW(DW), .TW(TW), .SHIFT(SHIFT)) u_cls (
         .prev_i     (win_p[c*DW +: DW]),
         .curr_i     (cur_q[c*DW +: DW]),
         .next_i     (win_n[c*DW +: DW]),
         .thr_i      (bus.spr_thr_edge),
         .original_o (orig_w[c]),
         .edge_o     (edge_w[c*4 +: 4])
      );
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q <= '0;
         prv_q <= '0;
         valid_q <= 1'b0;
         pix_q <= '0;
         border_q <= 1'b0;
         orig_q <= '0;
         edge_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q <= cur_d;
         prv_q <= prv_d;
         valid_q <= eval;
         pix_q <= eval ? cur_q : '0;
         border_q <= bdr;
         orig_q <= eval ? orig_w : '0;
         edge_q <= eval ? edge_w : '0;
      end
   end
   assign bus.o_valid = valid_q;
   assign bus.o_pix = pix_q;
   assign bus.o_border = border_q;
   assign bus.o_original = orig_q;
   assign bus.o_edge = edge_q;
`ifdef SPR_EDGE_STATS_EN
   logic [CW-1:0] cnt_q, cnt_d, lcnt_q;
   logic          stats_q;
   assign cnt_d = (|edge_w && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         lcnt_q <= '0;
         stats_q <= 1'b0;
      end else begin
         cnt_q <= (!bus.i_vs || last || state_q == IDLE) ? '0 : eval ? cnt_d : cnt_q;
         lcnt_q <= last ? cnt_d : lcnt_q;
         stats_q <= last;
      end
   end
   assign bus.o_line_edge_cnt = lcnt_q;
   assign bus.o_stats_valid = stats_q;
`endif
endmodule

// File: tb/tb_spr_edge_detect_mc.sv
// tb_spr_edge_detect_mc: directed lines against a queued reference of expected results
// SPR_EDGE_STATS_EN also checks the per-line edge count strobe
module tb_spr_edge_detect_mc;
   localparam int DW = 12, NCH = 3, TW = 12, SHIFT = 4, CW = 12, PW = NCH * DW;
   typedef struct {
      logic [PW-1:0]    pix;
      logic             border;
      logic [NCH-1:0]   orig;
      logic [4*NCH-1:0] edg;
      int               due;
      logic             last;
      int               cnt;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb[$];
   exp_t got;
   int n_chk = 0, n_fail = 0, cyc = 0, line_cnt = 0;
   logic [PW-1:0] lp [16];
   bit use_tab = 0;
   logic [3:0] tab_e [5] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0010};
   logic       tab_o [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic       tab_b [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   spr_edge_detect_mc_if #(.DW(DW), .NCH(NCH), .TW(TW), .CW(CW)) bus ();
   spr_edge_detect_mc #(.DW(DW), .NCH(NCH), .TW(TW), .SHIFT(SHIFT), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [3:0] mdl_edge(int p, int c, int n, int thr);
      int dp = c - p;
      int dn = c - n;
      int ap = (dp < 0 ? -dp : dp) >> SHIFT;
      int an = (dn < 0 ? -dn : dn) >> SHIFT;
      if (dp >= 0) return {ap >= thr && an >= thr, ap >= thr && an < thr, 2'b00};
      return {2'b00, ap >= thr && an <= thr, ap >= thr && an > thr};
   endfunction
   function automatic exp_t mdl(int k, int n, int thr);
      exp_t e;
      int kp = k > 0 ? k - 1 : 0;
      int kn = k < n - 1 ? k + 1 : n - 1;
      e.pix = lp[k];
      e.border = (k == 0) || (k == n - 1);
      for (int c = 0; c < NCH; c++) begin
         int p = int'(lp[kp][c*DW +: DW]);
         int cu = int'(lp[k][c*DW +: DW]);
         int nx = int'(lp[kn][c*DW +: DW]);
         e.orig[c] = (p == 0) ^ (cu == 0);
         e.edg[c*4 +: 4] = mdl_edge(p, cu, nx, thr);
      end
      e.due = 0;
      e.last = k == n - 1;
      e.cnt = 0;
      return e;
   endfunction
   task automatic push(input int k, input int n, input int thr);
      exp_t e = mdl(k, n, thr);
      if (use_tab) begin
         e.edg = '0;
         e.edg[3:0] = tab_e[k];
         e.orig = '0;
         e.orig[0] = tab_o[k];
         e.border = tab_b[k];
      end
      e.due = cyc + 2;
      if (|e.edg && line_cnt < 2**CW - 1) line_cnt++;
      e.cnt = line_cnt;
      sb.push_back(e);
   endtask
   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain", 64'(sb.size()), 64'd0);
   endtask
   // drop < 0: full line; otherwise i_vs falls after 'drop' accepted pixels
   task automatic send_line(input int n, input int drop, input int thr);
      int m = drop < 0 ? n : drop;
      line_cnt = 0;
      bus.spr_thr_edge = TW'(thr);
      for (int k = 0; k < m; k++) begin
         @(posedge clk); #1;
         bus.i_hs = 1'b1;
         bus.i_vs = 1'b1;
         bus.i_pix = lp[k];
         if (drop < 0 || k < m - 1) push(k, n, thr);
      end
      @(posedge clk); #1;
      if (drop < 0) bus.i_hs = 1'b0;
      else begin
         bus.i_vs = 1'b0;
         bus.i_pix = lp[m];
      end
      repeat (3) @(posedge clk);
      #1;
      bus.i_hs = 1'b0;
      bus.i_vs = 1'b1;
      drain();
   endtask
   always @(negedge clk) begin
      if (bus.o_valid === 1'b1) begin
         if (sb.size() == 0) chk("unexpected_valid", 64'(bus.o_valid), 64'd0);
         else begin
            got = sb.pop_front();
            chk("pix", 64'(bus.o_pix), 64'(got.pix));
            chk("border", 64'(bus.o_border), 64'(got.border));
            chk("original", 64'(bus.o_original), 64'(got.orig));
            chk("edge", 64'(bus.o_edge), 64'(got.edg));
            chk("latency", 64'(cyc), 64'(got.due));
`ifdef SPR_EDGE_STATS_EN
            chk("stats_valid", 64'(bus.o_stats_valid), 64'(got.last));
            if (got.last) chk("line_edge_cnt", 64'(bus.o_line_edge_cnt), 64'(got.cnt));
`endif
         end
      end else begin
         chk("valid_low", 64'(bus.o_valid), 64'd0);
         chk("idle_zero", 64'({bus.o_pix, bus.o_border, bus.o_original, bus.o_edge}), 64'd0);
`ifdef SPR_EDGE_STATS_EN
         chk("stats_idle", 64'(bus.o_stats_valid), 64'd0);
`endif
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.i_hs = 1'b0;
      bus.i_vs = 1'b0;
      bus.i_pix = '0;
      bus.spr_thr_edge = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 64'({bus.o_valid, bus.o_pix, bus.o_border, bus.o_original, bus.o_edge}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.i_vs = 1'b1;
      // edge classification line 0,0,100,100,0 on channel 0, thr=2
      lp[0] = 36'd0; lp[1] = 36'd0; lp[2] = 36'd100; lp[3] = 36'd100; lp[4] = 36'd0;
      use_tab = 1;
      send_line(5, -1, 2);
      use_tab = 0;
      // single-pixel line
      lp[0] = {12'd50, 12'd50, 12'd50};
      send_line(1, -1, 2);
      // i_vs drops after the third pixel of a six-pixel line
      for (int k = 0; k < 7; k++) lp[k] = {12'(k * 40), 12'(900 - k * 130), 12'(k * k * 60)};
      send_line(6, 3, 2);
      // ramp with a threshold no difference can reach
      for (int k = 0; k < 8; k++) lp[k] = {12'(k * 300), 12'(k * 200 + 7), 12'(k * 100)};
      send_line(8, -1, 4095);
      // an == thr on rising and falling steps
      lp[0] = 36'd200; lp[1] = 36'd0; lp[2] = 36'd32; lp[3] = 36'd100; lp[4] = 36'd68;
      send_line(5, -1, 2);
      // thr = 0 on a flat line and mixed channels
      for (int k = 0; k < 4; k++) lp[k] = {12'd5, 12'(k * 16), 12'(4095 - k * 700)};
      send_line(4, -1, 0);
      // random multi-channel line
      for (int k = 0; k < 12; k++) lp[k] = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 255)), 12'($urandom_range(0, 4095))};
      send_line(12, -1, int'($urandom_range(0, 8)));
      // asynchronous reset in the middle of a line with a result on the output
      line_cnt = 0;
      for (int k = 0; k < 6; k++) lp[k] = {12'(k * 500), 12'(k * 3), 12'(4000 - k * 600)};
      bus.spr_thr_edge = TW'(3);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         bus.i_hs = 1'b1;
         bus.i_pix = lp[k];
         push(k, 6, 3);
      end
      @(negedge clk);
      chk("pre_reset_valid", 64'(bus.o_valid), 64'd1);
      #2 rst = 1'b1;
      #1 chk("async_reset", 64'({bus.o_valid, bus.o_pix, bus.o_border, bus.o_original, bus.o_edge}), 64'd0);
      sb.delete();
      bus.i_hs = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      lp[0] = 36'd0; lp[1] = 36'd0; lp[2] = 36'd100; lp[3] = 36'd100; lp[4] = 36'd0;
      use_tab = 1;
      send_line(5, -1, 2);
      use_tab = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
